exu_stage: RTL
==============

# exu_stage

Registered execute stage for the NPC core, the successor to the single-cycle execute unit. It resolves ALU operations, branches and jumps, and adds an iterative RV32M multiply/divide path with a valid/ready handshake on both sides and a flush input. It sits between the ID/EX pipeline boundary and the LSU, and its redirect output drives the IFU.

## Interface
Parameters:
- XLEN, 32: datapath width. Only 32 is required to be legal; the RTL must not hard-code 32.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous kill of in-flight work
- in_valid  in  1  upstream has an op
- in_ready  out  1  stage can accept this cycle
- in_src1, in_src2  in  XLEN  ALU/MDU operands
- in_alu_ctrl  in  4  existing alu control encoding
- in_imm  in  XLEN  branch/jump offset
- in_pc  in  XLEN  pc-adder base
- in_funct3  in  3  branch condition or MDU op
- in_is_branch, in_is_jump, in_is_jalr, in_is_md  in  1 each  op class (at most one of branch/jump/md set)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  XLEN  ALU or MDU result
- out_dnpc  out  XLEN  next pc
- out_redirect  out  1  taken branch or jump

## Operation
- Reuses the existing alu instance (a=in_src1, b=in_src2, ctrl=in_alu_ctrl) for result, zero_flag and less_flag.
- Branch taken condition, by funct3:
  - 000: zero_flag
  - 001: !zero_flag
  - 100, 110: less_flag
  - 101, 111: !less_flag
  - 010, 011: never taken
- dnpc rules:
  - Taken branch or jump: dnpc = in_pc + in_imm.
  - Otherwise: dnpc = in_pc + 4.
  - in_is_jalr forces dnpc[0] = 0.
  - out_redirect = taken | in_is_jump.
- MDU ops, by funct3:
  - 000: MUL (low)
  - 001: MULH (s×s high)
  - 010: MULHSU
  - 011: MULHU
  - 100: DIV
  - 101: DIVU
  - 110: REM
  - 111: REMU
- MDU arithmetic:
  - Signed operands are converted to magnitudes.
  - Multiply is radix-2 shift-add over a 2·XLEN product; divide is restoring division.
  - The result sign is corrected after the last step.
  - REM takes the sign of the dividend.
- MDU special cases, which complete without iterating:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most negative ÷ −1): quotient = dividend, remainder = 0.
- FSM states and transitions:
  - IDLE: on accept of a non-MD or special-case op, go to DONE. On accept of an MD op, go to BUSY with the iteration counter loaded to XLEN−1.
  - BUSY: one iteration per cycle. When the counter reaches 0, latch the result and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, or re-accept if in_valid (see below).
- in_ready = (state==IDLE) | (state==DONE & out_ready), gated low by flush.
- Acceptance: an accept happens when in_valid & in_ready. All inputs are captured on accept and are not used afterwards.
- flush has priority over everything:
  - Next state is IDLE and out_valid=0 next cycle.
  - BUSY work is discarded.
  - No accept occurs in the flush cycle.

## Timing
- Reset (rst_n low, asynchronous) values:
  - state = IDLE, out_valid = 0, out_result = 0, out_dnpc = 0, out_redirect = 0.
  - in_ready = 1 once rst_n is high.
- Latency, measured from the accept edge:
  - Non-MD ops: out_valid high 1 cycle later.
  - MD special cases: 1 cycle.
  - MD ops: XLEN+1 cycles (33 at XLEN=32).
- Throughput: 1 op/cycle for non-MD ops under a continuous out_ready, because a DONE-state handoff and a new accept happen in the same cycle.
- Backpressure: while out_valid & !out_ready, all out_* outputs hold stable and in_ready=0.
- in_ready stays 0 for the whole of BUSY.
- rst_n asserted mid-BUSY returns the stage to its reset values immediately; no partial result is ever presented.

## Test plan
- Reset then idle: assert rst_n=0 mid-operation, then release → out_valid=0, all out_* =0, in_ready=1.
- BEQ taken: src1=src2=5, alu subtract, funct3=000, pc=0x80000000, imm=0x10 → out_dnpc=0x80000010, out_redirect=1. Same op with src2=6 → out_dnpc=0x80000004, out_redirect=0.
- JALR: pc=0x13, imm=0x4 → out_dnpc=0x16, out_redirect=1. pc=0x10, imm=0x3 → out_dnpc=0x12, bit0 cleared.
- MUL/MULH/MULHU: src1=0xFFFFFFFF, src2=2:
  - MUL → 0xFFFFFFFE
  - MULH → 0xFFFFFFFF
  - MULHU → 0x00000001
  - Each must take exactly 33 cycles to out_valid, with in_ready=0 throughout.
- DIV/REM: 
  - −7 ÷ 2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
  - x ÷ 0 → DIV 0xFFFFFFFF, REM x, in 1 cycle.
  - 0x80000000 ÷ −1 → DIV 0x80000000, REM 0.
- Handshake and flush:
  - Back-to-back ADDs with out_ready=1 → one result per cycle.
  - out_ready=0 for 3 cycles → outputs held stable.
  - flush asserted 10 cycles into a DIVU → out_valid never rises; the next ADD completes with 1-cycle latency.

Source files
------------

// File: rtl/exu_stage.sv
// Registered execute stage: ALU, branch/jump resolution and an iterative RV32M
// multiply/divide unit behind valid/ready handshakes, with a synchronous flush.
module exu_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_src1_i,
  input  logic [XLEN-1:0] in_src2_i,
  input  logic [3:0]      in_alu_ctrl_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [2:0]      in_funct3_i,
  input  logic            in_is_branch_i,
  input  logic            in_is_jump_i,
  input  logic            in_is_jalr_i,
  input  logic            in_is_md_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output logic [XLEN-1:0] out_dnpc_o,
  output logic            out_redirect_o
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] PcStep  = XLEN'(4);

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluSll  = 4'b0001;
  localparam logic [3:0] AluSlt  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSra  = 4'b1101;
  localparam logic [3:0] AluOr   = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] dnpc_q, dnpc_d;
  logic            redir_q, redir_d;

  // ALU
  logic [XLEN-1:0] alu_res;
  logic [CntW-1:0] shamt;
  logic            less_s, less_u, less_flag, zero_flag;

  assign shamt  = in_src2_i[CntW-1:0];
  assign less_s = $signed(in_src1_i) < $signed(in_src2_i);
  assign less_u = in_src1_i < in_src2_i;

  always_comb begin
    alu_res = '0;
    case (in_alu_ctrl_i)
      AluAdd:  alu_res = in_src1_i + in_src2_i;
      AluSub:  alu_res = in_src1_i - in_src2_i;
      AluSll:  alu_res = in_src1_i << shamt;
      AluSlt:  alu_res = {{(XLEN-1){1'b0}}, less_s};
      AluSltu: alu_res = {{(XLEN-1){1'b0}}, less_u};
      AluXor:  alu_res = in_src1_i ^ in_src2_i;
      AluSrl:  alu_res = in_src1_i >> shamt;
      AluSra:  alu_res = $unsigned($signed(in_src1_i) >>> shamt);
      AluOr:   alu_res = in_src1_i | in_src2_i;
      AluAnd:  alu_res = in_src1_i & in_src2_i;
      default: alu_res = '0;
    endcase
  end

  // Signedness of the comparison follows the ALU control: SLTU selects unsigned.
  assign less_flag = (in_alu_ctrl_i == AluSltu) ? less_u : less_s;
  assign zero_flag = (alu_res == '0);

  // Branch / next-pc
  logic            br_cond, taken;
  logic [XLEN-1:0] dnpc_calc;

  always_comb begin
    case (in_funct3_i)
      3'b000:         br_cond = zero_flag;
      3'b001:         br_cond = !zero_flag;
      3'b100, 3'b110: br_cond = less_flag;
      3'b101, 3'b111: br_cond = !less_flag;
      default:        br_cond = 1'b0;
    endcase
    taken     = in_is_branch_i & br_cond;
    dnpc_calc = (taken | in_is_jump_i) ? in_pc_i + in_imm_i : in_pc_i + PcStep;
    if (in_is_jalr_i) dnpc_calc[0] = 1'b0;
  end

  // MDU operand setup
  logic            a_signed, b_signed, a_neg, b_neg, is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, md_special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed    = (in_funct3_i == 3'b001) | (in_funct3_i == 3'b010) |
                  (in_funct3_i == 3'b100) | (in_funct3_i == 3'b110);
    b_signed    = (in_funct3_i == 3'b001) | (in_funct3_i == 3'b100) |
                  (in_funct3_i == 3'b110);
    a_neg       = a_signed & in_src1_i[XLEN-1];
    b_neg       = b_signed & in_src2_i[XLEN-1];
    a_mag       = a_neg ? -in_src1_i : in_src1_i;
    b_mag       = b_neg ? -in_src2_i : in_src2_i;
    is_div      = in_funct3_i[2];
    div_zero    = is_div & (in_src2_i == '0);
    div_ovf     = is_div & !in_funct3_i[0] & (in_src1_i == MinNeg) & (in_src2_i == '1);
    md_special  = div_zero | div_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) special_res = in_funct3_i[1] ? in_src1_i : '1;
    else          special_res = in_funct3_i[1] ? '0 : in_src1_i;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, div_raw, div_res, mul_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
    mul_hi    = mul_sum[XLEN:1];
    mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_hi    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], !div_diff[XLEN]};
    prod      = {mul_hi, mul_lo};
    prod_fix  = neg_q ? -prod : prod;
    mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_raw   = op_q[1] ? div_hi : div_lo;
    div_res   = neg_q ? -div_raw : div_raw;
  end

  // Handshake and FSM
  logic accept;

  assign in_ready_o = !flush_i & ((state_q == StIdle) | ((state_q == StDone) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    dnpc_d  = dnpc_q;
    redir_d = redir_q;

    if (accept) begin
      dnpc_d  = dnpc_calc;
      redir_d = taken | in_is_jump_i;
      if (in_is_md_i && !md_special) begin
        state_d = StBusy;
        cnt_d   = CntLast;
        op_d    = in_funct3_i;
        hi_d    = '0;
        lo_d    = is_div ? a_mag : b_mag;
        mcand_d = is_div ? b_mag : a_mag;
        neg_d   = (is_div & in_funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
      end else begin
        state_d = StDone;
        res_d   = in_is_md_i ? special_res : alu_res;
      end
    end else begin
      case (state_q)
        StBusy: begin
          hi_d  = op_q[2] ? div_hi : mul_hi;
          lo_d  = op_q[2] ? div_lo : mul_lo;
          cnt_d = cnt_q - CntOne;
          if (cnt_q == '0) begin
            res_d   = op_q[2] ? div_res : mul_res;
            state_d = StDone;
          end
        end
        StDone:  if (out_ready_i) state_d = StIdle;
        default: state_d = state_q;
      endcase
    end

    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      dnpc_q  <= '0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      dnpc_q  <= dnpc_d;
      redir_q <= redir_d;
    end
  end

  assign out_valid_o    = (state_q == StDone);
  assign out_result_o   = res_q;
  assign out_dnpc_o     = dnpc_q;
  assign out_redirect_o = redir_q;

endmodule
